io_responder: RTL and testbench
===============================

// Module: io_responder
// PURPOSE
//  Memory-mapped I/O responder: answers CPU data-bus loads/stores for KEY, SW, HEX, LEDR, LEDG.
//  Sits beside data memory at the top level; the CPU routes addresses >= 0xF0000000 here.
//  Synchronizes board inputs, latches key events into a status register and holds output registers.
//  Drives the four 7-segment displays.
// PARAMETERS
//  DBITS            32           bus data/address width
//  ADDR_HEX         32'hF0000000 HEX data (R/W, bits[15:0], one nibble per digit)
//  ADDR_LEDR        32'hF0000004 LEDR data (R/W, bits[9:0])
//  ADDR_LEDG        32'hF0000008 LEDG data (R/W, bits[7:0])
//  ADDR_KEY         32'hF0000010 KEY data (R only, bits[3:0], 1 = pressed)
//  ADDR_SW          32'hF0000014 SW data (R only, bits[9:0])
//  ADDR_KCTRL       32'hF0000110 key status (R/W: bit0 ready, bit2 overrun)
//  DEBOUNCE_CYCLES  100000       stable cycles required before an SW change is accepted
// PORTS
//  clk      in   1      system clock (PLL c0)
//  reset    in   1      asynchronous, active-low reset
//  addr     in   DBITS  bus address
//  rdEn     in   1      load in progress this cycle
//  wrEn     in   1      store in progress this cycle
//  wrData   in   DBITS  store data
//  rdData   out  DBITS  load data; 0 when the address is not decoded
//  KEY      in   4      board keys, active-low
//  SW       in   10     board switches
//  LEDR     out  10     red LEDs
//  LEDG     out  8      green LEDs
//  HEX0..3  out  7 each seven-segment displays, active-low segments; HEX0 = nibble[3:0]
// BEHAVIOUR
//  Reset (reset=0, async): HEX reg=0, so every digit shows "0"; LEDR=0, LEDG=0; kdata=0; ksync=0;
//   swdata=0; KCTRL=0; debounce counter=0.
//  Reads are combinational (zero latency) from registered state. Writes commit on the rising clk edge.
//  Writes to KEY/SW are ignored. Unmapped addresses: reads return 0, writes have no effect.
//  KEY path: 2-flop synchronizer on ~KEY. kdata updates when the synchronized value differs.
//   - On a kdata change: if ready=1, set overrun=1. Then set ready=1.
//  KCTRL: writing 0 to bit2 clears overrun. Writing 1 to bit2 is ignored.
//   - Writing 1 to bit0 is ignored. Writing 0 to bit0 clears ready.
//  Read of ADDR_KEY with rdEn=1 clears ready at the clock edge.
//  Simultaneous events: if a kdata change and a clear (KEY read or KCTRL write) occur in the same cycle,
//   the change wins, so ready=1. The overrun update is computed from ready before the clear.
//  SW path: 2-flop synchronizer feeds the debouncer (see CONFIGURATION). Its output is swdata.
//  Upper unused rdData bits are 0.
//  HEX digits are decoded combinationally from the HEX reg.
//   Digits 0-F follow the standard DE-board patterns; e.g. 0 -> 7'b1000000.
// CONFIGURATION
//  IO_SW_DEBOUNCE_EN defined:
//   - When the synchronized SW differs from swdata, a counter increments each cycle.
//   - The counter resets to 0 whenever the synchronized SW changes or equals swdata.
//   - At DEBOUNCE_CYCLES-1 the synchronized value is loaded into swdata and the counter clears.
//   - Counter width: $clog2(DEBOUNCE_CYCLES).
//  IO_SW_DEBOUNCE_EN undefined: swdata = synchronized SW. Latency is 2 cycles and no counter is built.
// STRUCTURE
//  Shared package io_defs: all ADDR_* constants, KCTRL bit indices (KCTRL_RDY=0, KCTRL_OVR=2),
//   DBITS. Shared with the CPU top level for the address compare.
//  Sub-module seven_seg_decoder: 4-bit in -> 7-bit active-low out, purely combinational,
//   instantiated 4x.
// TESTING
//  1 Reset then read ADDR_HEX, ADDR_LEDR, ADDR_LEDG, ADDR_KCTRL -> all 0; HEX0..3 = 7'b1000000.
//  2 Write 16'h1A2F to HEX -> HEX0=F, HEX1=2, HEX2=A, HEX3=1 patterns;
//    write 10'h3FF to LEDR -> LEDR all on; read back matches.
//  3 Drive KEY=4'b1110 -> after 2-3 cycles, KEY read=1 and KCTRL=1.
//    Then drive KEY=4'b1111 with no read -> KCTRL=5. Write 0 to KCTRL -> KCTRL=0.
//  4 Change a key in the same cycle as an ADDR_KEY read -> ready stays 1 and overrun is unchanged.
//  5 With IO_SW_DEBOUNCE_EN and DEBOUNCE_CYCLES=8: toggle SW[0] with glitches shorter than 8 cycles
//    -> swdata unchanged. Hold SW[0]=1 -> SW read =1 exactly 2+8 cycles after the last edge.
//    Without the macro -> SW read =1 after 2 cycles.
//  6 Assert reset mid-debounce and with ready=1 -> all state clears asynchronously.
//    Read of unmapped 32'hF0000020 -> 0; a write there has no effect.

Source files
------------

// File: rtl/io_responder_pkg.sv
// io_defs: address map and key-status bit positions for the memory-mapped
// I/O responder. The CPU top level imports this same package so that its
// ">= 0xF0000000" routing compare and this block's decode stay in step.
package io_defs;

  localparam int DBITS = 32;

  localparam logic [DBITS-1:0] ADDR_HEX   = 32'hF000_0000;
  localparam logic [DBITS-1:0] ADDR_LEDR  = 32'hF000_0004;
  localparam logic [DBITS-1:0] ADDR_LEDG  = 32'hF000_0008;
  localparam logic [DBITS-1:0] ADDR_KEY   = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_SW    = 32'hF000_0014;
  localparam logic [DBITS-1:0] ADDR_KCTRL = 32'hF000_0110;

  localparam int KCTRL_RDY = 0;
  localparam int KCTRL_OVR = 2;

  localparam int HEX_W  = 16;
  localparam int LEDR_W = 10;
  localparam int LEDG_W = 8;
  localparam int KEY_W  = 4;
  localparam int SW_W   = 10;

  // One-hot-free select code produced by the address decoder
  typedef enum logic [2:0] {
    SEL_NONE  = 3'd0,
    SEL_HEX   = 3'd1,
    SEL_LEDR  = 3'd2,
    SEL_LEDG  = 3'd3,
    SEL_KEY   = 3'd4,
    SEL_SW    = 3'd5,
    SEL_KCTRL = 3'd6
  } io_sel_e;

  // Full 32-bit compare: near-miss addresses must fall through to SEL_NONE
  function automatic io_sel_e decode_addr(input logic [DBITS-1:0] a);
    io_sel_e sel;
    sel = SEL_NONE;
    case (a)
      ADDR_HEX:   sel = SEL_HEX;
      ADDR_LEDR:  sel = SEL_LEDR;
      ADDR_LEDG:  sel = SEL_LEDG;
      ADDR_KEY:   sel = SEL_KEY;
      ADDR_SW:    sel = SEL_SW;
      ADDR_KCTRL: sel = SEL_KCTRL;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/io_responder_seven_seg.sv
// seven_seg_decoder: hex nibble to active-low 7-segment pattern, DE-board
// segment order {g,f,e,d,c,b,a}. Purely combinational.
module seven_seg_decoder (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  // Nibble to segment lookup
  always_comb begin
    o_seg_n = 7'b1111111;
    case (i_nibble)
      4'h0: o_seg_n = 7'b1000000;
      4'h1: o_seg_n = 7'b1111001;
      4'h2: o_seg_n = 7'b0100100;
      4'h3: o_seg_n = 7'b0110000;
      4'h4: o_seg_n = 7'b0011001;
      4'h5: o_seg_n = 7'b0010010;
      4'h6: o_seg_n = 7'b0000010;
      4'h7: o_seg_n = 7'b1111000;
      4'h8: o_seg_n = 7'b0000000;
      4'h9: o_seg_n = 7'b0010000;
      4'hA: o_seg_n = 7'b0001000;
      4'hB: o_seg_n = 7'b0000011;
      4'hC: o_seg_n = 7'b1000110;
      4'hD: o_seg_n = 7'b0100001;
      4'hE: o_seg_n = 7'b0000110;
      4'hF: o_seg_n = 7'b0001110;
      default: o_seg_n = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped responder for KEY, SW, HEX, LEDR and LEDG.
// Loads are answered combinationally from registered state (rdData follows
// addr directly; rdEn only matters for the ready-clearing side effect of a
// KEY load). Stores commit on the rising clock edge.
// Build option: define IO_SW_DEBOUNCE_EN to put a stable-time debouncer
// behind the SW synchronizer; otherwise SW is the plain 2-flop synchronized
// value and no counter is built.
module io_responder
  import io_defs::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DBITS-1:0]  addr,
  input  logic              rdEn,
  input  logic              wrEn,
  input  logic [DBITS-1:0]  wrData,
  output logic [DBITS-1:0]  rdData,
  input  logic [KEY_W-1:0]  KEY,
  input  logic [SW_W-1:0]   SW,
  output logic [LEDR_W-1:0] LEDR,
  output logic [LEDG_W-1:0] LEDG,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3
);

  io_sel_e w_sel;

  logic w_wr_hex;
  logic w_wr_ledr;
  logic w_wr_ledg;
  logic w_wr_kctrl;
  logic w_rd_key;

  logic [HEX_W-1:0]  r_hex;
  logic [LEDR_W-1:0] r_ledr;
  logic [LEDG_W-1:0] r_ledg;

  logic [KEY_W-1:0] r_ksync1;
  logic [KEY_W-1:0] r_ksync2;
  logic [KEY_W-1:0] r_kdata;
  logic             r_rdy;
  logic             r_ovr;

  logic w_kchange;
  logic w_clr_rdy;
  logic w_clr_ovr;

  logic [SW_W-1:0] r_sw_s1;
  logic [SW_W-1:0] r_sw_s2;
  logic [SW_W-1:0] w_swdata;

  logic [DBITS-1:0] w_rd_data;
  logic             w_unused;

  assign w_sel = decode_addr(addr);

  assign w_wr_hex   = wrEn && (w_sel == SEL_HEX);
  assign w_wr_ledr  = wrEn && (w_sel == SEL_LEDR);
  assign w_wr_ledg  = wrEn && (w_sel == SEL_LEDG);
  assign w_wr_kctrl = wrEn && (w_sel == SEL_KCTRL);
  assign w_rd_key   = rdEn && (w_sel == SEL_KEY);

  // Output registers written by stores
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hex  <= '0;
      r_ledr <= '0;
      r_ledg <= '0;
    end else begin
      if (w_wr_hex)  r_hex  <= wrData[HEX_W-1:0];
      if (w_wr_ledr) r_ledr <= wrData[LEDR_W-1:0];
      if (w_wr_ledg) r_ledg <= wrData[LEDG_W-1:0];
    end
  end

  assign LEDR = r_ledr;
  assign LEDG = r_ledg;

  // Key synchronizer; keys are inverted so 1 means pressed from here on
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ksync1 <= '0;
      r_ksync2 <= '0;
    end else begin
      r_ksync1 <= ~KEY;
      r_ksync2 <= r_ksync1;
    end
  end

  assign w_kchange = (r_ksync2 != r_kdata);

  // Only a written 0 clears a status bit; written 1s are ignored
  assign w_clr_rdy = w_rd_key || (w_wr_kctrl && !wrData[KCTRL_RDY]);
  assign w_clr_ovr = w_wr_kctrl && !wrData[KCTRL_OVR];

  // Key data and status: a fresh key event beats a same-cycle clear, and
  // overrun looks at ready as it was before any clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kdata <= '0;
      r_rdy   <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (w_kchange) r_kdata <= r_ksync2;
      r_rdy <= w_kchange || (r_rdy && !w_clr_rdy);
      r_ovr <= (w_kchange && r_rdy) || (r_ovr && !w_clr_ovr);
    end
  end

  // Switch synchronizer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
    end else begin
      r_sw_s1 <= SW;
      r_sw_s2 <= r_sw_s1;
    end
  end

`ifdef IO_SW_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_db_cnt;
  logic [SW_W-1:0]  r_swdata;

  // Debouncer: r_sw_s1 != r_sw_s2 flags that the synchronized value is
  // changing at this edge, which restarts the stable-time count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_db_cnt <= '0;
      r_swdata <= '0;
    end else if ((r_sw_s2 == r_swdata) || (r_sw_s1 != r_sw_s2)) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == CNT_LAST) begin
      r_swdata <= r_sw_s2;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  assign w_swdata = r_swdata;
`else
  assign w_swdata = r_sw_s2;
`endif

  // Load data mux; unused upper bits and undecoded addresses read as 0
  always_comb begin
    w_rd_data = '0;
    case (w_sel)
      SEL_HEX:   w_rd_data[HEX_W-1:0]  = r_hex;
      SEL_LEDR:  w_rd_data[LEDR_W-1:0] = r_ledr;
      SEL_LEDG:  w_rd_data[LEDG_W-1:0] = r_ledg;
      SEL_KEY:   w_rd_data[KEY_W-1:0]  = r_kdata;
      SEL_SW:    w_rd_data[SW_W-1:0]   = w_swdata;
      SEL_KCTRL: begin
        w_rd_data[KCTRL_RDY] = r_rdy;
        w_rd_data[KCTRL_OVR] = r_ovr;
      end
      default:   w_rd_data = '0;
    endcase
  end

  assign rdData = w_rd_data;

  seven_seg_decoder u_hex0 (.i_nibble(r_hex[3:0]),   .o_seg_n(HEX0));
  seven_seg_decoder u_hex1 (.i_nibble(r_hex[7:4]),   .o_seg_n(HEX1));
  seven_seg_decoder u_hex2 (.i_nibble(r_hex[11:8]),  .o_seg_n(HEX2));
  seven_seg_decoder u_hex3 (.i_nibble(r_hex[15:12]), .o_seg_n(HEX3));

  // Store data above the widest register is never looked at
  assign w_unused = &{1'b0, wrData[DBITS-1:HEX_W], DEBOUNCE_CYCLES[0]};

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder. Inputs change on the falling edge;
// registered state is observed on the falling edge after the rising edge
// that updated it. Compile with +define+IO_SW_DEBOUNCE_EN to exercise the
// debouncer (instance uses DEBOUNCE_CYCLES=8).
module tb_io_responder;

  localparam logic [31:0] A_HEX   = 32'hF000_0000;
  localparam logic [31:0] A_LEDR  = 32'hF000_0004;
  localparam logic [31:0] A_LEDG  = 32'hF000_0008;
  localparam logic [31:0] A_KEY   = 32'hF000_0010;
  localparam logic [31:0] A_SW    = 32'hF000_0014;
  localparam logic [31:0] A_KCTRL = 32'hF000_0110;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        rdEn;
  logic        wrEn;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;

  int n_pass  = 0;
  int n_total = 0;

  logic [6:0] seg_tbl [16];

  io_responder #(.DEBOUNCE_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .rdEn(rdEn), .wrEn(wrEn),
    .wrData(wrData), .rdData(rdData), .KEY(KEY), .SW(SW),
    .LEDR(LEDR), .LEDG(LEDG), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wrData = d; wrEn = 1'b1;
    @(negedge clk);
    wrEn = 1'b0; wrData = '0; addr = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; rdEn = 1'b1;
    #1 d = rdData;
    @(negedge clk);
    rdEn = 1'b0; addr = '0;
  endtask

  task automatic peek(input logic [31:0] a, output logic [31:0] d);
    addr = a; rdEn = 1'b0;
    #1 d = rdData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [6];
    logic [6:0]  hx [4];
    addrs = '{A_HEX, A_LEDR, A_LEDG, A_KCTRL, A_KEY, A_SW};
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      peek(addrs[i], d);
      n_total++;
      if (d !== 32'h0) $display("FAIL rst_read[%0d]: got %h required %h", i, d, 32'h0);
      else n_pass++;
    end
    hx = '{HEX0, HEX1, HEX2, HEX3};
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (hx[i] !== 7'b1000000) $display("FAIL rst_hex%0d: got %b required %b", i, hx[i], 7'b1000000);
      else n_pass++;
    end
    n_total++;
    if (LEDR !== 10'h0 || LEDG !== 8'h0) $display("FAIL rst_leds: got %h/%h required 0/0", LEDR, LEDG);
    else n_pass++;
  endtask

  task automatic test_out_regs();
    logic [31:0] d;
    @(negedge clk);
    bus_write(A_HEX, 32'hFFFF_1A2F);
    bus_read(A_HEX, d);
    n_total++;
    if (d !== 32'h0000_1A2F) $display("FAIL hex_read: got %h required %h", d, 32'h0000_1A2F);
    else n_pass++;
    n_total++;
    if ({HEX3, HEX2, HEX1, HEX0} !== {7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110})
      $display("FAIL hex_1a2f: got %b_%b_%b_%b required 1111001_0001000_0100100_0001110", HEX3, HEX2, HEX1, HEX0);
    else n_pass++;
    bus_write(A_LEDR, 32'hFFFF_FFFF);
    bus_read(A_LEDR, d);
    n_total++;
    if (d !== 32'h0000_03FF || LEDR !== 10'h3FF) $display("FAIL ledr_all: got %h/%h required 3ff/3ff", d, LEDR);
    else n_pass++;
    bus_write(A_LEDG, 32'h0000_01A5);
    bus_read(A_LEDG, d);
    n_total++;
    if (d !== 32'h0000_00A5 || LEDG !== 8'hA5) $display("FAIL ledg: got %h/%h required a5/a5", d, LEDG);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      bus_write(A_HEX, 32'(i));
      n_total++;
      if (HEX0 !== seg_tbl[i] || HEX1 !== 7'b1000000)
        $display("FAIL hex_digit[%0d]: got %b/%b required %b/1000000", i, HEX0, HEX1, seg_tbl[i]);
      else n_pass++;
    end
    bus_write(A_KEY, 32'h0000_000F);
    bus_write(A_SW, 32'h0000_03FF);
    peek(A_KEY, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL key_wr_ignored: got %h required 0", d);
    else n_pass++;
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL sw_wr_ignored: got %h required 0", d);
    else n_pass++;
  endtask

  task automatic test_key();
    logic [31:0] d;
    @(negedge clk);
    KEY = 4'b1110;
    tick(2);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL key_sync_latency: got %h required 0", d);
    else n_pass++;
    tick(1);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL key_ready: got %h required 1", d);
    else n_pass++;
    peek(A_KEY, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL key_data: got %h required 1", d);
    else n_pass++;
    KEY = 4'b1111;
    tick(3);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h5) $display("FAIL key_overrun: got %h required 5", d);
    else n_pass++;
    @(negedge clk);
    bus_write(A_KCTRL, 32'h4);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h4) $display("FAIL kctrl_clr_rdy: got %h required 4", d);
    else n_pass++;
    @(negedge clk);
    bus_write(A_KCTRL, 32'h0);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL kctrl_clr_all: got %h required 0", d);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] d;
    @(negedge clk);
    KEY = 4'b1101;
    tick(2);
    bus_read(A_KEY, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL sim_read_old: got %h required 0", d);
    else n_pass++;
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL sim_change_wins: got %h required 1", d);
    else n_pass++;
    peek(A_KEY, d);
    n_total++;
    if (d !== 32'h2) $display("FAIL sim_kdata: got %h required 2", d);
    else n_pass++;
    KEY = 4'b1111;
    tick(2);
    bus_read(A_KEY, d);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h5) $display("FAIL sim_ovr_pre_clear: got %h required 5", d);
    else n_pass++;
    @(negedge clk);
    bus_read(A_KEY, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL key_release_data: got %h required 0", d);
    else n_pass++;
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h4) $display("FAIL key_read_clears_rdy: got %h required 4", d);
    else n_pass++;
    @(negedge clk);
    bus_write(A_KCTRL, 32'h5);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h4) $display("FAIL kctrl_ones_ignored: got %h required 4", d);
    else n_pass++;
    @(negedge clk);
    bus_write(A_KCTRL, 32'h1);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL kctrl_clr_ovr: got %h required 0", d);
    else n_pass++;
  endtask

  task automatic test_sw();
    logic [31:0] d;
    @(negedge clk);
`ifdef IO_SW_DEBOUNCE_EN
    SW = 10'h001;
    tick(5);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL db_glitch5: got %h required 0", d);
    else n_pass++;
    SW = 10'h000;
    tick(3);
    SW = 10'h001;
    tick(7);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL db_glitch7: got %h required 0", d);
    else n_pass++;
    SW = 10'h000;
    tick(12);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL db_settled: got %h required 0", d);
    else n_pass++;
    @(negedge clk);
    SW = 10'h001;
    tick(9);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL db_early: got %h required 0", d);
    else n_pass++;
    tick(1);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL db_accept: got %h required 1", d);
    else n_pass++;
    SW = 10'h000;
    tick(12);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL db_release: got %h required 0", d);
    else n_pass++;
`else
    SW = 10'h001;
    tick(1);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL sw_early: got %h required 0", d);
    else n_pass++;
    tick(1);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL sw_2cyc: got %h required 1", d);
    else n_pass++;
    SW = 10'h2A5;
    tick(2);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h2A5) $display("FAIL sw_pattern: got %h required 2a5", d);
    else n_pass++;
    SW = 10'h000;
    tick(2);
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL sw_release: got %h required 0", d);
    else n_pass++;
`endif
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    @(negedge clk);
    bus_write(A_LEDR, 32'h155);
    bus_write(A_LEDG, 32'h3C);
    bus_write(A_HEX, 32'h1234);
    KEY = 4'b1110;
    SW  = 10'h001;
    tick(4);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h1) $display("FAIL pre_rst_ready: got %h required 1", d);
    else n_pass++;
    #2 reset = 1'b0;
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL arst_kctrl: got %h required 0", d);
    else n_pass++;
    peek(A_KEY, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL arst_kdata: got %h required 0", d);
    else n_pass++;
    peek(A_SW, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL arst_sw: got %h required 0", d);
    else n_pass++;
    n_total++;
    if (LEDR !== 10'h0 || LEDG !== 8'h0 || HEX0 !== 7'b1000000 || HEX3 !== 7'b1000000)
      $display("FAIL arst_outputs: got %h/%h/%b/%b required 0/0/1000000/1000000", LEDR, LEDG, HEX0, HEX3);
    else n_pass++;
    KEY = 4'b1111;
    SW  = 10'h000;
    @(negedge clk);
    reset = 1'b1;
    tick(3);
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL post_rst_kctrl: got %h required 0", d);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [31:0] bad [4];
    bad = '{32'hF000_0020, 32'hF000_000C, 32'hF000_0011, 32'hF000_0114};
    @(negedge clk);
    bus_write(A_HEX, 32'h00C3);
    bus_write(A_LEDR, 32'h02A);
    bus_write(A_LEDG, 32'h05C);
    for (int i = 0; i < 4; i++) begin
      bus_read(bad[i], d);
      n_total++;
      if (d !== 32'h0) $display("FAIL unmapped_read[%0d]: got %h required 0", i, d);
      else n_pass++;
    end
    bus_write(32'hF000_0020, 32'hFFFF_FFFF);
    bus_write(32'hF000_0001, 32'hFFFF_FFFF);
    peek(A_HEX, d);
    n_total++;
    if (d !== 32'h00C3) $display("FAIL unmapped_wr_hex: got %h required c3", d);
    else n_pass++;
    peek(A_LEDR, d);
    n_total++;
    if (d !== 32'h02A) $display("FAIL unmapped_wr_ledr: got %h required 2a", d);
    else n_pass++;
    peek(A_LEDG, d);
    n_total++;
    if (d !== 32'h05C) $display("FAIL unmapped_wr_ledg: got %h required 5c", d);
    else n_pass++;
    peek(A_KCTRL, d);
    n_total++;
    if (d !== 32'h0) $display("FAIL unmapped_wr_kctrl: got %h required 0", d);
    else n_pass++;
  endtask

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    reset  = 1'b0;
    addr   = '0;
    rdEn   = 1'b0;
    wrEn   = 1'b0;
    wrData = '0;
    KEY    = 4'b1111;
    SW     = 10'h000;

    test_reset();
    test_out_regs();
    test_key();
    test_simultaneous();
    test_sw();
    test_async_reset();
    test_unmapped();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
